// File: rtl/his_peak_finder.sv
// rtl/his_peak_finder.sv - per-pixel histogram peak scan with optional bin clear
// Reads every bin once, one per cycle, and reports the max-count bin of each pixel.
module his_peak_finder #(
   parameter int NB        = 8,
   parameter int BIN_NUM   = 256,
   parameter int PIXEL_NUM = 4,
   parameter int PIX_W     = 2,
   parameter int RAM_ADDR  = 10,
   parameter int COUNT_W   = 8,
   parameter int CLEAR_EN  = 1
) (
   input  logic                clk,
   input  logic                res,
   input  logic                start,
   output logic [RAM_ADDR-1:0] raddr,
   output logic                rEnable,
   input  logic [COUNT_W-1:0]  rdata,
   output logic [RAM_ADDR-1:0] waddr,
   output logic                wEnable,
   output logic [COUNT_W-1:0]  wdata,
   output logic                busy,
   output logic                peak_valid,
   output logic [PIX_W-1:0]    peak_pixel,
   output logic [NB-1:0]       peak_bin,
   output logic [COUNT_W-1:0]  peak_count,
   output logic                done
);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FLUSH, S_DONE} state_t;

   localparam logic [NB-1:0]       LAST_BIN  = NB'(BIN_NUM - 1);
   localparam logic [RAM_ADDR-1:0] LAST_ADDR = RAM_ADDR'(PIXEL_NUM * BIN_NUM - 1);

   state_t              state_q, state_d;
   logic [RAM_ADDR-1:0] raddr_q, raddr_d;
   logic                ren_q, ren_d;
   logic [NB-1:0]       iss_bin_q, iss_bin_d;
   logic [PIX_W-1:0]    iss_pix_q, iss_pix_d;
   logic                pend_valid_q, pend_valid_d;
   logic [RAM_ADDR-1:0] pend_addr_q, pend_addr_d;
   logic [NB-1:0]       pend_bin_q, pend_bin_d;
   logic [PIX_W-1:0]    pend_pix_q, pend_pix_d;
   logic [COUNT_W-1:0]  max_q, max_d;
   logic [NB-1:0]       max_bin_q, max_bin_d;
   logic                wen_q, wen_d;
   logic [RAM_ADDR-1:0] waddr_q, waddr_d;
   logic                busy_q, busy_d;
   logic                pv_q, pv_d;
   logic [PIX_W-1:0]    pp_q, pp_d;
   logic [NB-1:0]       pb_q, pb_d;
   logic [COUNT_W-1:0]  pc_q, pc_d;
   logic                done_q, done_d;

   always_comb begin
      state_d      = state_q;
      raddr_d      = raddr_q;
      ren_d        = 1'b0;
      iss_bin_d    = iss_bin_q;
      iss_pix_d    = iss_pix_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      // The pipeline stage always tracks what the read port presented this cycle.
      pend_valid_d = ren_q;
      pend_addr_d  = raddr_q;
      pend_bin_d   = iss_bin_q;
      pend_pix_d   = iss_pix_q;
      max_d        = max_q;
      max_bin_d    = max_bin_q;
      wen_d        = 1'b0;
      waddr_d      = waddr_q;
      pv_d         = 1'b0;
      pp_d         = pp_q;
      pb_d         = pb_q;
      pc_d         = pc_q;

      if (pend_valid_q) begin
         // Bin 0 reloads unconditionally; strict compare keeps the lowest bin on ties.
         if (pend_bin_q == '0 || rdata > max_q) begin
            max_d     = rdata;
            max_bin_d = pend_bin_q;
         end
         if (pend_bin_q == LAST_BIN) begin
            pv_d = 1'b1;
            pp_d = pend_pix_q;
            pb_d = max_bin_d;
            pc_d = max_d;
         end
         if (CLEAR_EN != 0) begin
            wen_d   = 1'b1;
            waddr_d = pend_addr_q;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_SCAN;
               raddr_d   = '0;
               ren_d     = 1'b1;
               iss_bin_d = '0;
               iss_pix_d = '0;
               busy_d    = 1'b1;
            end
         end
         S_SCAN: begin
            if (raddr_q == LAST_ADDR) begin
               state_d = S_FLUSH;
            end else begin
               raddr_d = raddr_q + 1'b1;
               ren_d   = 1'b1;
               if (iss_bin_q == LAST_BIN) begin
                  iss_bin_d = '0;
                  iss_pix_d = iss_pix_q + 1'b1;
               end else begin
                  iss_bin_d = iss_bin_q + 1'b1;
               end
            end
         end
         S_FLUSH: state_d = S_DONE;
         S_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!res) begin
         state_q      <= S_IDLE;
         raddr_q      <= '0;
         ren_q        <= 1'b0;
         iss_bin_q    <= '0;
         iss_pix_q    <= '0;
         pend_valid_q <= 1'b0;
         pend_addr_q  <= '0;
         pend_bin_q   <= '0;
         pend_pix_q   <= '0;
         max_q        <= '0;
         max_bin_q    <= '0;
         wen_q        <= 1'b0;
         waddr_q      <= '0;
         busy_q       <= 1'b0;
         pv_q         <= 1'b0;
         pp_q         <= '0;
         pb_q         <= '0;
         pc_q         <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         raddr_q      <= raddr_d;
         ren_q        <= ren_d;
         iss_bin_q    <= iss_bin_d;
         iss_pix_q    <= iss_pix_d;
         pend_valid_q <= pend_valid_d;
         pend_addr_q  <= pend_addr_d;
         pend_bin_q   <= pend_bin_d;
         pend_pix_q   <= pend_pix_d;
         max_q        <= max_d;
         max_bin_q    <= max_bin_d;
         wen_q        <= wen_d;
         waddr_q      <= waddr_d;
         busy_q       <= busy_d;
         pv_q         <= pv_d;
         pp_q         <= pp_d;
         pb_q         <= pb_d;
         pc_q         <= pc_d;
         done_q       <= done_d;
      end
   end

   assign raddr      = raddr_q;
   assign rEnable    = ren_q;
   assign waddr      = waddr_q;
   assign wEnable    = wen_q;
   assign wdata      = '0;
   assign busy       = busy_q;
   assign peak_valid = pv_q;
   assign peak_pixel = pp_q;
   assign peak_bin   = pb_q;
   assign peak_count = pc_q;
   assign done       = done_q;

endmodule

// File: tb/tb_his_peak_finder.sv
// tb/tb_his_peak_finder.sv - scoreboard bench for his_peak_finder
// Instance 0 runs without clear, instance 1 with clear; both see the same RAM image and start.
module tb_his_peak_finder;

   typedef struct {int pix; int bin; int cnt; int t;} pk_t;

   logic clk = 1'b0;
   logic res, start, load;
   logic chk_idle, chk_clr, chk_end;

   logic [5:0] raddr [2];
   logic [5:0] waddr [2];
   logic       ren   [2];
   logic       wen   [2];
   logic       busy  [2];
   logic       pv    [2];
   logic       dn    [2];
   logic [7:0] rdata [2];
   logic [7:0] wdata [2];
   logic [7:0] pc    [2];
   logic [1:0] pp    [2];
   logic [3:0] pb    [2];

   logic [7:0] img  [64];
   logic [7:0] ram0 [64];
   logic [7:0] ram1 [64];

   pk_t q0[$];
   pk_t q1[$];
   int  qd[$];
   int  tests = 0;
   int  fails = 0;
   int  ncnt  = 1000;
   int  rd_at [64];
   int  wcnt  [64];
   int  w0cnt = 0;

   always #5 clk = ~clk;

   his_peak_finder #(.NB(4), .BIN_NUM(16), .PIXEL_NUM(4), .PIX_W(2), .RAM_ADDR(6),
                     .COUNT_W(8), .CLEAR_EN(0)) dut0 (
      .clk(clk), .res(res), .start(start), .raddr(raddr[0]), .rEnable(ren[0]),
      .rdata(rdata[0]), .waddr(waddr[0]), .wEnable(wen[0]), .wdata(wdata[0]),
      .busy(busy[0]), .peak_valid(pv[0]), .peak_pixel(pp[0]), .peak_bin(pb[0]),
      .peak_count(pc[0]), .done(dn[0]));

   his_peak_finder #(.NB(4), .BIN_NUM(16), .PIXEL_NUM(4), .PIX_W(2), .RAM_ADDR(6),
                     .COUNT_W(8), .CLEAR_EN(1)) dut1 (
      .clk(clk), .res(res), .start(start), .raddr(raddr[1]), .rEnable(ren[1]),
      .rdata(rdata[1]), .waddr(waddr[1]), .wEnable(wen[1]), .wdata(wdata[1]),
      .busy(busy[1]), .peak_valid(pv[1]), .peak_pixel(pp[1]), .peak_bin(pb[1]),
      .peak_count(pc[1]), .done(dn[1]));

   always @(posedge clk) begin
      if (load) begin
         ram0 <= img;
         ram1 <= img;
      end else begin
         if (wen[0]) ram0[waddr[0]] <= wdata[0];
         if (wen[1]) ram1[waddr[1]] <= wdata[1];
      end
      if (ren[0]) rdata[0] <= ram0[raddr[0]];
      if (ren[1]) rdata[1] <= ram1[raddr[1]];
   end

   // Edges since the last accepted start; the start edge itself is 0.
   always @(posedge clk) begin
      if (start && res && !busy[0]) ncnt <= 0;
      else                          ncnt <= ncnt + 1;
   end

   task automatic check(input bit ok, input string msg);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s", msg);
      end
   endtask

   initial begin : monitor
      pk_t e;
      int  d, bad;
      forever begin
         @(negedge clk);
         if (ncnt == 0) begin
            for (int a = 0; a < 64; a++) wcnt[a] = 0;
            w0cnt = 0;
         end
         if (wen[0]) w0cnt++;
         if (ren[1]) rd_at[raddr[1]] = ncnt;
         if (wen[1]) begin
            check(ncnt - rd_at[waddr[1]] == 2 && wdata[1] == 8'd0,
                  $sformatf("clear_write addr=%0d delay=%0d wdata=%0d required delay=2 wdata=0",
                            waddr[1], ncnt - rd_at[waddr[1]], wdata[1]));
            wcnt[waddr[1]]++;
         end
         for (int i = 0; i < 2; i++) begin
            if (pv[i]) begin
               if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                  check(1'b0, $sformatf("peak%0d_unexpected got (%0d,%0d,%0d) at %0d required none",
                                        i, pp[i], pb[i], pc[i], ncnt));
               end else begin
                  if (i == 0) e = q0.pop_front();
                  else        e = q1.pop_front();
                  check(pp[i] == e.pix && pb[i] == e.bin && pc[i] == e.cnt && ncnt == e.t,
                        $sformatf("peak%0d got (%0d,%0d,%0d)@%0d required (%0d,%0d,%0d)@%0d",
                                  i, pp[i], pb[i], pc[i], ncnt, e.pix, e.bin, e.cnt, e.t));
               end
            end
         end
         if (dn[0] || dn[1]) begin
            if (qd.size() == 0) begin
               check(1'b0, $sformatf("done_unexpected at %0d required none", ncnt));
            end else begin
               d = qd.pop_front();
               check(dn[0] && dn[1] && ncnt == d,
                     $sformatf("done got %0b%0b@%0d required 11@%0d", dn[0], dn[1], ncnt, d));
            end
         end
         if (chk_idle) begin
            for (int i = 0; i < 2; i++)
               check({raddr[i], ren[i], waddr[i], wen[i], wdata[i], busy[i], pv[i],
                      pp[i], pb[i], pc[i], dn[i]} == '0,
                     $sformatf("idle%0d outputs=%h required 0", i,
                               {raddr[i], ren[i], waddr[i], wen[i], wdata[i], busy[i], pv[i],
                                pp[i], pb[i], pc[i], dn[i]}));
         end
         if (chk_clr) begin
            bad = 0;
            for (int a = 0; a < 64; a++) if (wcnt[a] != 1) bad++;
            check(bad == 0 && w0cnt == 0,
                  $sformatf("clear_count bad_addrs=%0d noclear_writes=%0d required 0 and 0",
                            bad, w0cnt));
         end
         if (chk_end)
            check(q0.size() == 0 && q1.size() == 0 && qd.size() == 0,
                  $sformatf("leftover q0=%0d q1=%0d qd=%0d required 0", q0.size(), q1.size(),
                            qd.size()));
      end
   end

   task automatic expect_pk(input int which, input int p, input int b, input int c);
      pk_t e;
      e.pix = p; e.bin = b; e.cnt = c; e.t = 17 + 16 * p;
      if (which != 1) q0.push_back(e);
      if (which != 0) q1.push_back(e);
   endtask

   task automatic ref_peak(input int p, output int b, output int c);
      b = 0;
      c = int'(img[p * 16]);
      for (int k = 1; k < 16; k++)
         if (int'(img[p * 16 + k]) > c) begin
            c = int'(img[p * 16 + k]);
            b = k;
         end
   endtask

   task automatic load_ram();
      @(posedge clk); #1 load = 1'b1;
      @(posedge clk); #1 load = 1'b0;
   endtask

   task automatic idle_check();
      @(posedge clk); #1 chk_idle = 1'b1;
      @(negedge clk); #1 chk_idle = 1'b0;
   endtask

   task automatic fill_a();
      for (int a = 0; a < 64; a++) img[a] = 8'd1;
      for (int p = 0; p < 4; p++) img[p * 16 + 3 * p + 1] = 8'(10 + p);
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic scan(input int restart_at);
      int i;
      qd.push_back(66);
      pulse_start();
      if (restart_at > 0) begin
         repeat (restart_at - 1) @(posedge clk);
         #1 start = 1'b1;
         @(posedge clk); #1 start = 1'b0;
      end
      i = 0;
      while (!dn[0] && i < 200) begin
         @(negedge clk);
         i++;
      end
      @(posedge clk); #1 chk_clr = 1'b1;
      @(negedge clk); #1 chk_clr = 1'b0;
   endtask

   initial begin : stim
      int b, c;
      res = 1'b0; start = 1'b0; load = 1'b0;
      chk_idle = 1'b0; chk_clr = 1'b0; chk_end = 1'b0;
      for (int a = 0; a < 64; a++) img[a] = 8'd0;
      repeat (3) @(posedge clk);
      idle_check();

      // start coincident with reset must be dropped
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0; res = 1'b1;
      idle_check();

      fill_a();
      load_ram();
      expect_pk(2, 0, 1, 10); expect_pk(2, 1, 4, 11);
      expect_pk(2, 2, 7, 12); expect_pk(2, 3, 10, 13);
      scan(0);

      for (int a = 0; a < 16; a++) img[a] = 8'd3;
      img[5] = 8'd50; img[9] = 8'd50;
      for (int a = 16; a < 32; a++) img[a] = 8'd0;
      for (int a = 32; a < 48; a++) img[a] = 8'd7;
      img[47] = 8'd255;
      for (int a = 48; a < 64; a++) img[a] = 8'd200;
      img[48] = 8'd255; img[56] = 8'd255;
      load_ram();
      expect_pk(2, 0, 5, 50); expect_pk(2, 1, 0, 0);
      expect_pk(2, 2, 15, 255); expect_pk(2, 3, 0, 255);
      scan(0);

      fill_a();
      load_ram();
      expect_pk(2, 0, 1, 10); expect_pk(2, 1, 4, 11);
      expect_pk(2, 2, 7, 12); expect_pk(2, 3, 10, 13);
      scan(20);

      for (int a = 0; a < 64; a++) img[a] = 8'($urandom_range(0, 255));
      load_ram();
      for (int p = 0; p < 4; p++) begin
         ref_peak(p, b, c);
         expect_pk(2, p, b, c);
      end
      scan(0);
      for (int p = 0; p < 4; p++) begin
         ref_peak(p, b, c);
         expect_pk(0, p, b, c);
         expect_pk(1, p, 0, 0);
      end
      scan(0);

      // reset mid-scan: only pixel 0 completes before the abort
      fill_a();
      load_ram();
      expect_pk(2, 0, 1, 10);
      pulse_start();
      repeat (29) @(posedge clk);
      #1 res = 1'b0;
      idle_check();
      res = 1'b1;
      repeat (80) @(posedge clk);
      load_ram();
      expect_pk(2, 0, 1, 10); expect_pk(2, 1, 4, 11);
      expect_pk(2, 2, 7, 12); expect_pk(2, 3, 10, 13);
      scan(0);

      @(posedge clk); #1 chk_end = 1'b1;
      @(negedge clk); #1 chk_end = 1'b0;
      @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
